sat_narrow_pipe: RTL and testbench

- Narrows a wide signed datapath value to a smaller signed width: the inverse of the pipeline's sign-extension path.
- Sits on the store/result-writeback side, where 32-bit ALU results are packed into 16-bit halfword fields.
- Two-stage registered pipeline with a valid/ready handshake on both sides.
- Per-word selectable saturation or wrap truncation, plus sticky and counted overflow reporting.

---
 rtl/sat_narrow_pipe.sv | 118 +++++++++++
 tb/tb_sat_narrow_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sat_narrow_pipe.sv
// Two-stage valid/ready pipeline that narrows a signed IN_W value to OUT_W bits,
// saturating or wrapping on overflow, with sticky and counted overflow reporting.
module sat_narrow_pipe #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  data_in,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] data_out,
    output logic             ovf,
    output logic             ovf_sticky,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int unsigned HI_W = IN_W - OUT_W + 1;

    logic             s1_valid;
    logic [OUT_W-1:0] s1_low;
    logic             s1_sign;
    logic             s1_sat;
    logic             s1_ovf;

    logic             s2_load;
    logic             accept;
    logic             s1_adv;
    logic             ovf_event;
    logic             in_ovf;
    logic [HI_W-1:0]  in_hi;
    logic [OUT_W-1:0] narrow;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_d;
    logic             sticky_d;

    assign s2_load   = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load;
    assign accept    = in_valid && in_ready;
    assign s1_adv    = s1_valid && s2_load;
    assign ovf_event = out_valid && out_ready && ovf;

    // In range only when the discarded bits plus the new sign bit are all equal.
    assign in_hi  = data_in[IN_W-1:OUT_W-1];
    assign in_ovf = !((&in_hi) || !(|in_hi));

    always_comb begin
        narrow = s1_low;
        if (s1_ovf && s1_sat) begin
            narrow = s1_sign ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    // Clear takes effect first, so a same-cycle event lands on a zeroed counter.
    always_comb begin
        cnt_base = ovf_clr ? '0 : ovf_count;
        sticky_d = ovf_clr ? 1'b0 : ovf_sticky;
        cnt_d    = cnt_base;
        if (ovf_event) begin
            sticky_d = 1'b1;
            if (cnt_base != {CNT_W{1'b1}}) begin
                cnt_d = cnt_base + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_low   <= '0;
            s1_sign  <= 1'b0;
            s1_sat   <= 1'b0;
            s1_ovf   <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_low   <= data_in[OUT_W-1:0];
                s1_sign  <= data_in[IN_W-1];
                s1_sat   <= sat_en;
                s1_ovf   <= in_ovf;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            ovf       <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid <= s1_valid;
            end
            if (s1_adv) begin
                data_out <= narrow;
                ovf      <= s1_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else begin
            ovf_sticky <= sticky_d;
            ovf_count  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sat_narrow_pipe.sv
// Directed self-checking bench for sat_narrow_pipe (32->16), plus a CNT_W=2 instance
// for counter saturation.
module tb_sat_narrow_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, sat_en, out_valid, out_ready;
    logic [31:0] data_in;
    logic [15:0] data_out;
    logic        ovf, ovf_sticky, ovf_clr;
    logic [15:0] ovf_count;

    logic        b_in_valid, b_in_ready, b_sat_en, b_out_valid, b_ovf, b_ovf_sticky;
    logic [31:0] b_data_in;
    logic [15:0] b_data_out;
    logic [1:0]  b_ovf_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sat_narrow_pipe #(.IN_W(32), .OUT_W(16), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .sat_en     (sat_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .ovf        (ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr),
        .ovf_count  (ovf_count)
    );

    sat_narrow_pipe #(.IN_W(32), .OUT_W(16), .CNT_W(2)) dut_c2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .data_in    (b_data_in),
        .sat_en     (b_sat_en),
        .out_valid  (b_out_valid),
        .out_ready  (1'b1),
        .data_out   (b_data_out),
        .ovf        (b_ovf),
        .ovf_sticky (b_ovf_sticky),
        .ovf_clr    (1'b0),
        .ovf_count  (b_ovf_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sends one word into an empty pipe with out_ready high and checks the 2-cycle latency.
    task automatic send_one(input string tag, input logic [31:0] d, input logic s,
                            input logic [15:0] exp_d, input logic exp_o, input logic clr);
        @(negedge clk);
        in_valid = 1'b1; data_in = d; sat_en = s;
        #1 check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        ovf_clr = clr;
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_dat"}, 32'(data_out), 32'(exp_d));
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_o));
        @(negedge clk);
        ovf_clr = 1'b0;
    endtask

    logic [31:0] vec [5];
    int idx, k, first, last;
    logic acc, seen;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; data_in = '0; sat_en = 1'b1;
        out_ready = 1'b1; ovf_clr = 1'b0;
        b_in_valid = 1'b0; b_data_in = '0; b_sat_en = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_sticky", 32'(ovf_sticky), 32'd0);
        check("rst_count", 32'(ovf_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);

        send_one("inr_pos", 32'h0000_1234, 1'b1, 16'h1234, 1'b0, 1'b0);
        send_one("inr_neg", 32'hFFFF_8000, 1'b1, 16'h8000, 1'b0, 1'b0);
        check("inr_count", 32'(ovf_count), 32'd0);
        send_one("sat_pos", 32'h0000_8000, 1'b1, 16'h7FFF, 1'b1, 1'b0);
        send_one("sat_neg", 32'hFFFF_7FFF, 1'b1, 16'h8000, 1'b1, 1'b0);
        send_one("sat_min", 32'h8000_0000, 1'b1, 16'h8000, 1'b1, 1'b0);
        check("sat_sticky", 32'(ovf_sticky), 32'd1);
        check("sat_count", 32'(ovf_count), 32'd3);
        send_one("wrap", 32'h0001_2345, 1'b0, 16'h2345, 1'b1, 1'b0);
        check("wrap_count", 32'(ovf_count), 32'd4);

        @(negedge clk) ovf_clr = 1'b1;
        @(negedge clk) ovf_clr = 1'b0;
        check("clr_count", 32'(ovf_count), 32'd0);
        check("clr_sticky", 32'(ovf_sticky), 32'd0);
        send_one("clr_evt", 32'h0002_0000, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        check("clr_evt_count", 32'(ovf_count), 32'd1);
        check("clr_evt_sticky", 32'(ovf_sticky), 32'd1);

        // Backpressure: 6 cycles of offered words with the sink stalled.
        vec[0] = 32'h11; vec[1] = 32'h22; vec[2] = 32'h33; vec[3] = 32'h44; vec[4] = 32'h55;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; data_in = vec[idx]; sat_en = 1'b1;
            #1 acc = in_ready;
            if (out_valid) check("bp_hold", 32'(data_out), vec[0]);
            @(posedge clk);
            if (acc) idx++;
        end
        @(negedge clk);
        #1;
        check("bp_accepted", 32'(idx), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_data_a", 32'(data_out), vec[0]);
        k = 0; first = -1; last = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (idx < 5);
            if (idx < 5) data_in = vec[idx];
            #1 acc = in_valid && in_ready;
            if (out_valid) begin
                if (k < 5) check("bp_order", 32'(data_out), vec[k]);
                else check("bp_dup", 32'(out_valid), 32'd0);
                if (k == 0) first = c;
                last = c;
                k++;
            end
            @(posedge clk);
            if (acc) idx++;
        end
        check("bp_count", 32'(k), 32'd5);
        check("bp_rate", 32'(last - first), 32'd4);
        check("bp_no_ovf", 32'(ovf_count), 32'd1);

        // Counter saturation on the CNT_W=2 instance.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            b_in_valid = 1'b1; b_data_in = 32'h0001_0000;
        end
        @(negedge clk) b_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("c2_count", 32'(b_ovf_count), 32'd3);
        check("c2_sticky", 32'(b_ovf_sticky), 32'd1);
        check("c2_data", 32'(b_data_out), 32'h7FFF);

        // Reset with two words buffered.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; data_in = 32'h0000_0077;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_pre_vld", 32'(out_valid), 32'd1);
        check("mid_pre_rdy", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_count", 32'(ovf_count), 32'd0);
        check("mid_sticky", 32'(ovf_sticky), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("mid_no_ghost", 32'(seen), 32'd0);
        send_one("post_rst", 32'hFFFF_FFFE, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
